// File: rtl/decode_queue_stage_pkg.sv
// rtl/decode_queue_stage_pkg.sv - LC-3 opcode, decoded-field types and the decode function
package decode_stage_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RES  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } opcode_e;

  typedef struct packed {
    opcode_e    opcode;
    logic [2:0] dr;
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic       imm_mode;
    logic       reg_write;
    logic       mem_rd;
    logic       mem_wr;
    logic       mem_ind;
    logic       illegal;
  } decoded_s;

  function automatic decoded_s decode_instr(input logic [15:0] instr);
    decoded_s d;
    opcode_e  op;
    op       = opcode_e'(instr[15:12]);
    d        = '0;
    d.opcode = op;
    d.dr     = instr[11:9];
    d.sr1    = instr[8:6];
    case (op)
      OP_ADD, OP_AND: begin
        d.sr2       = instr[2:0];
        d.imm_mode  = instr[5];
        d.reg_write = 1'b1;
      end
      OP_NOT, OP_LEA: d.reg_write = 1'b1;
      OP_LD, OP_LDR: begin
        d.reg_write = 1'b1;
        d.mem_rd    = 1'b1;
      end
      OP_LDI: begin
        d.reg_write = 1'b1;
        d.mem_rd    = 1'b1;
        d.mem_ind   = 1'b1;
      end
      // Stores read their data register from the dr slot
      OP_ST, OP_STR: begin
        d.sr2    = instr[11:9];
        d.mem_wr = 1'b1;
      end
      OP_STI: begin
        d.sr2     = instr[11:9];
        d.mem_wr  = 1'b1;
        d.mem_ind = 1'b1;
      end
      OP_JSR, OP_RTI, OP_RES, OP_TRAP: d.illegal = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_queue_stage_if.sv
// rtl/decode_queue_stage_if.sv - fetch-side push and execute-side handshake bundle
interface decode_queue_stage_if #(
  parameter int DEPTH = 4,
  parameter int NPC_W = 16
);
  logic                     enable_decode;
  logic [15:0]              dout;
  logic [NPC_W-1:0]         npc_in;
  logic                     flush;
  logic                     in_ready;
  logic [$clog2(DEPTH):0]   count;
  logic                     out_valid;
  logic                     out_ready;
  logic [15:0]              ir;
  logic [NPC_W-1:0]         npc_out;
  logic [3:0]               opcode;
  logic [2:0]               dr;
  logic [2:0]               sr1;
  logic [2:0]               sr2;
  logic                     imm_mode;
  logic                     reg_write;
  logic                     mem_rd;
  logic                     mem_wr;
  logic                     mem_ind;
  logic                     illegal;

  modport slave (
    input  enable_decode, dout, npc_in, flush, out_ready,
    output in_ready, count, out_valid, ir, npc_out, opcode, dr, sr1, sr2,
           imm_mode, reg_write, mem_rd, mem_wr, mem_ind, illegal
  );

  modport master (
    output enable_decode, dout, npc_in, flush, out_ready,
    input  in_ready, count, out_valid, ir, npc_out, opcode, dr, sr1, sr2,
           imm_mode, reg_write, mem_rd, mem_wr, mem_ind, illegal
  );
endinterface

// File: rtl/decode_queue_stage_fifo.sv
// rtl/decode_queue_stage_fifo.sv - synchronous FIFO holding instruction/NPC pairs
module decode_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/decode_queue_stage.sv
// rtl/decode_queue_stage.sv - buffered LC-3 decode stage with registered decoded outputs
module decode_queue_stage
  import decode_stage_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NPC_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  decode_queue_stage_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 16 + NPC_W;

  logic [CW-1:0]    occ;
  logic [EW-1:0]    head;
  logic             in_ready;
  logic             push;
  logic             load;
  decoded_s         head_dec;

  logic             out_valid_q;
  logic [15:0]      ir_q;
  logic [NPC_W-1:0] npc_q;
  decoded_s         dec_q;

  assign in_ready = (occ != CW'(DEPTH));
  assign push     = bus.enable_decode & in_ready & ~bus.flush;
  assign load     = (~out_valid_q | bus.out_ready) & (occ != '0) & ~bus.flush;

  decode_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (load),
    .flush (bus.flush),
    .wdata ({bus.dout, bus.npc_in}),
    .rdata (head),
    .count (occ)
  );

  assign head_dec = decode_instr(head[EW-1:NPC_W]);

  // Fields only change on a load, so they hold while execute stalls
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      ir_q        <= '0;
      npc_q       <= '0;
      dec_q       <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      ir_q        <= head[EW-1:NPC_W];
      npc_q       <= head[NPC_W-1:0];
      dec_q       <= head_dec;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.count     = occ;
  assign bus.out_valid = out_valid_q;
  assign bus.ir        = ir_q;
  assign bus.npc_out   = npc_q;
  assign bus.opcode    = dec_q.opcode;
  assign bus.dr        = dec_q.dr;
  assign bus.sr1       = dec_q.sr1;
  assign bus.sr2       = dec_q.sr2;
  assign bus.imm_mode  = dec_q.imm_mode;
  assign bus.reg_write = dec_q.reg_write;
  assign bus.mem_rd    = dec_q.mem_rd;
  assign bus.mem_wr    = dec_q.mem_wr;
  assign bus.mem_ind   = dec_q.mem_ind;
  assign bus.illegal   = dec_q.illegal;

endmodule
